// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the load port of one register among four requesters.
// Clear requests take priority; an optional idle gap is enforced after every load.
module reg_write_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GAP   = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [3:0]         req_i,
    input  logic [4*WIDTH-1:0] req_data_i,
    input  logic               clr_i,
    output logic [3:0]         ack_o,
    output logic               reg_load_o,
    output logic [WIDTH-1:0]   reg_data_o,
    output logic               reg_clear_o,
    output logic [1:0]         grant_id_o,
    output logic [15:0]        write_count_o,
    output logic               busy_o
);

    localparam logic [0:0] StArb     = 1'b0;
    localparam logic [0:0] StHoldoff = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       ack_q, ack_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             clear_q, clear_d;
    logic [15:0]      count_q, count_d;
    logic             busy_q, busy_d;

    logic [3:0] eligible;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;

    // The requester acked this cycle is masked so a held req is not granted twice.
    assign eligible = req_i & ~ack_q;

    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        ptr_d     = ptr_q;
        ack_d     = 4'b0000;
        load_d    = 1'b0;
        data_d    = data_q;
        clear_d   = 1'b0;
        count_d   = count_q;
        // busy lags the state by one cycle so it covers exactly the idle cycles after a load.
        busy_d    = (state_q == StHoldoff);
        case (state_q)
            StArb: begin
                if (clr_i) begin
                    clear_d = 1'b1;
                end else if (found) begin
                    load_d     = 1'b1;
                    data_d     = req_data_i[win*WIDTH +: WIDTH];
                    ack_d[win] = 1'b1;
                    ptr_d      = win;
                    count_d    = count_q + 16'd1;
                    if (GAP > 0) begin
                        state_d   = StHoldoff;
                        gap_cnt_d = 4'(GAP - 1);
                    end
                end
            end
            StHoldoff: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = StArb;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StArb;
            gap_cnt_q <= 4'd0;
            ptr_q     <= 2'd3;
            ack_q     <= 4'b0000;
            load_q    <= 1'b0;
            data_q    <= '0;
            clear_q   <= 1'b0;
            count_q   <= 16'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            load_q    <= load_d;
            data_q    <= data_d;
            clear_q   <= clear_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
        end
    end

    assign ack_o         = ack_q;
    assign reg_load_o    = load_q;
    assign reg_data_o    = data_q;
    assign reg_clear_o   = clear_q;
    assign grant_id_o    = ptr_q;
    assign write_count_o = count_q;
    assign busy_o        = busy_q;

endmodule
